// File: rtl/mac_tx_arbiter.sv
// Two-requester transmit arbiter in front of an Ethernet MAC encoder: grants one frame at a time,
// streams its payload, then enforces a hold-off gap. Define TX_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module mac_tx_arbiter #(
    parameter logic [7:0] HOLDOFF_CYCLES = 8'd110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [47:0] dest0,
    input  logic [47:0] dest1,
    input  logic [15:0] type0,
    input  logic [15:0] type1,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    input  logic        last0,
    input  logic        last1,
    output logic        grant0,
    output logic        grant1,
    output logic        ready0,
    output logic        ready1,
    input  logic        send_next,
    output logic        en,
    output logic [7:0]  mac_payload,
    output logic [47:0] mac_dest,
    output logic [15:0] ethertype
);

    typedef enum logic [1:0] {IDLE, HEADER, STREAM, HOLDOFF} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  payload_q, payload_d;
    logic [47:0] dest_q, dest_d;
    logic [15:0] type_q, type_d;
    logic [7:0]  cnt_q, cnt_d;
    // Set once the last byte is latched; keeps en/grant up for exactly one more cycle.
    logic        done_q, done_d;
    logic        win;
    logic [1:0]  ready;
    logic [7:0]  data_sel;
    logic        last_sel;

`ifdef TX_ARB_FIXED_PRIO_EN
    always_comb begin
        win = ~req0;
    end
`else
    // rr_q = 1 means requester 1 has priority on the next tie.
    logic rr_q, rr_d;

    always_comb begin
        if (req0 && req1) begin
            win = rr_q;
        end else begin
            win = ~req0;
        end
    end
`endif

    assign ready    = (state_q == STREAM && !done_q && send_next) ? grant_q : 2'b00;
    assign data_sel = grant_q[1] ? data1 : data0;
    assign last_sel = grant_q[1] ? last1 : last0;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        grant_d   = grant_q;
        payload_d = payload_q;
        dest_d    = dest_q;
        type_d    = type_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
`ifndef TX_ARB_FIXED_PRIO_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = win ? 2'b10 : 2'b01;
                    dest_d  = win ? dest1 : dest0;
                    type_d  = win ? type1 : type0;
                    en_d    = 1'b1;
                    done_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = HEADER;
`ifndef TX_ARB_FIXED_PRIO_EN
                    rr_d    = ~win;
`endif
                end
            end
            HEADER: begin
                if (send_next) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (done_q) begin
                    en_d    = 1'b0;
                    grant_d = 2'b00;
                    done_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = HOLDOFF;
                end else if (|ready) begin
                    payload_d = data_sel;
                    done_d    = last_sel;
                end
            end
            HOLDOFF: begin
                if ({1'b0, cnt_q} + 9'd1 >= {1'b0, HOLDOFF_CYCLES}) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            grant_q   <= 2'b00;
            payload_q <= 8'd0;
            dest_q    <= 48'd0;
            type_q    <= 16'd0;
            cnt_q     <= 8'd0;
            done_q    <= 1'b0;
`ifndef TX_ARB_FIXED_PRIO_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            grant_q   <= grant_d;
            payload_q <= payload_d;
            dest_q    <= dest_d;
            type_q    <= type_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
`ifndef TX_ARB_FIXED_PRIO_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign grant0      = grant_q[0];
    assign grant1      = grant_q[1];
    assign ready0      = ready[0];
    assign ready1      = ready[1];
    assign en          = en_q;
    assign mac_payload = payload_q;
    assign mac_dest    = dest_q;
    assign ethertype   = type_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter: per-scenario tasks, payload scoreboard and per-cycle invariants.
module tb_mac_tx_arbiter;

    localparam int HO = 110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0;
    logic [47:0] dest0 = '0, dest1 = '0;
    logic [15:0] type0 = '0, type1 = '0;
    logic [7:0]  data0 = '0, data1 = '0;
    logic        last0 = 0, last1 = 0;
    logic        send_next = 1'b1;
    logic        grant0, grant1, ready0, ready1, en;
    logic [7:0]  mac_payload;
    logic [47:0] mac_dest;
    logic [15:0] ethertype;

    int          checks = 0;
    int          errors = 0;
    bit          sn_rand = 1'b0;
    logic [7:0]  sb[$];

    mac_tx_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .dest0(dest0), .dest1(dest1),
        .type0(type0), .type1(type1),
        .data0(data0), .data1(data1),
        .last0(last0), .last1(last1),
        .grant0(grant0), .grant1(grant1),
        .ready0(ready0), .ready1(ready1),
        .send_next(send_next), .en(en),
        .mac_payload(mac_payload), .mac_dest(mac_dest), .ethertype(ethertype)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            send_next = sn_rand ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    // Payload scoreboard: a ready seen before an edge must land the pushed byte; otherwise payload holds.
    initial begin
        logic       r, rs;
        logic [7:0] prev, exp;
        forever begin
            @(negedge clk);
            r = ready0 | ready1;
            rs = rst;
            prev = mac_payload;
            @(posedge clk);
            #1;
            if (!rs) begin
                checks++;
                if (r) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL payload: byte %h accepted with empty scoreboard", mac_payload);
                    end else begin
                        exp = sb.pop_front();
                        if (mac_payload !== exp) begin
                            errors++;
                            $display("FAIL payload: got %h expected %h", mac_payload, exp);
                        end
                    end
                end else if (mac_payload !== prev) begin
                    errors++;
                    $display("FAIL payload_hold: got %h expected %h", mac_payload, prev);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((grant0 && grant1) || (ready0 && !grant0) || (ready1 && !grant1) ||
                ((ready0 || ready1) && (!send_next || !en))) begin
                errors++;
                $display("FAIL invariant: g=%b%b r=%b%b sn=%b en=%b expected onehot grant, ready only with grant/send_next/en",
                         grant1, grant0, ready1, ready0, send_next, en);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input int n, input logic r, input logic [47:0] dst, input logic [15:0] typ,
                          input logic [7:0] dat, input logic lst);
        if (n == 0) begin
            req0 = r; dest0 = dst; type0 = typ; data0 = dat; last0 = lst;
        end else begin
            req1 = r; dest1 = dst; type1 = typ; data1 = dat; last1 = lst;
        end
    endtask

    // Drives one frame of len bytes base, base+1, ...; drops req after byte drop_at when drop_at >= 0.
    task automatic drive_frame(input int n, input logic [47:0] dst, input logic [15:0] typ,
                               input int len, input logic [7:0] base, input int drop_at);
        int   i = 0;
        int   cyc = 0;
        bit   seen = 0;
        logic rdy, gnt;
        set_in(n, 1'b1, dst, typ, base, len == 1);
        while (i < len) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                errors++;
                $display("FAIL drive%0d_timeout: accepted %0d expected %0d bytes", n, i, len);
                set_in(n, 1'b0, dst, typ, 8'h00, 1'b0);
                return;
            end
            rdy = (n == 0) ? ready0 : ready1;
            gnt = (n == 0) ? grant0 : grant1;
            if (gnt && !seen) begin
                seen = 1;
                checks++;
                if (mac_dest !== dst || ethertype !== typ || rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL header%0d: dest %h type %h ready %b expected %h %h 0",
                             n, mac_dest, ethertype, rdy, dst, typ);
                end
            end
            if (drop_at >= 0 && i >= drop_at) begin
                if (n == 0) req0 = 1'b0; else req1 = 1'b0;
                checks++;
                if (gnt !== 1'b1 || en !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_hold%0d: grant %b en %b expected 1 1", n, gnt, en);
                end
            end
            if (rdy) begin
                sb.push_back(base + 8'(i));
                @(posedge clk);
                #1;
                i++;
                if (i < len) begin
                    set_in(n, !(drop_at >= 0 && i >= drop_at), dst, typ, base + 8'(i), i == len - 1);
                end
            end
        end
        gnt = (n == 0) ? grant0 : grant1;
        checks++;
        if (en !== 1'b1 || gnt !== 1'b1) begin
            errors++;
            $display("FAIL last_hold%0d: en %b grant %b expected 1 1", n, en, gnt);
        end
        set_in(n, 1'b0, dst, typ, 8'h00, 1'b0);
        @(negedge clk);
        rdy = (n == 0) ? ready0 : ready1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL extra_ready%0d: ready %b expected 0", n, rdy);
        end
        @(posedge clk);
        #1;
        gnt = (n == 0) ? grant0 : grant1;
        checks++;
        if (en !== 1'b0 || gnt !== 1'b0) begin
            errors++;
            $display("FAIL frame_end%0d: en %b grant %b expected 0 0", n, en, gnt);
        end
    endtask

    // Checks the order of the next n grants and the en-low gap between them
    // (HOLDOFF_CYCLES of hold-off plus the IDLE arbitration cycle).
    task automatic watch_grants(input int n, input int w0, input int w1, input int w2, input int first_gap);
        int exp_w[3];
        int gap = 0;
        int to;
        int w;
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            to = 0;
            while (!(grant0 || grant1)) begin
                gap++;
                to++;
                if (to > 3000) begin
                    errors++;
                    $display("FAIL grant_timeout: grant %0d got none expected requester %0d", k, exp_w[k]);
                    return;
                end
                @(negedge clk);
            end
            w = grant1 ? 1 : 0;
            checks++;
            if (w != exp_w[k]) begin
                errors++;
                $display("FAIL winner%0d: got requester %0d expected %0d", k, w, exp_w[k]);
            end
            checks++;
            if (gap != ((k == 0) ? first_gap : HO + 1)) begin
                errors++;
                $display("FAIL gap%0d: got %0d cycles expected %0d", k, gap, (k == 0) ? first_gap : HO + 1);
            end
            to = 0;
            while (grant0 || grant1) begin
                to++;
                if (to > 3000) begin
                    errors++;
                    $display("FAIL grant_stuck: grant %0d never released", k);
                    return;
                end
                @(negedge clk);
            end
            gap = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (en !== 1'b0 || grant0 !== 1'b0 || grant1 !== 1'b0 || ready0 !== 1'b0 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: en %b grant %b%b ready %b%b expected all 0", en, grant1, grant0, ready1, ready0);
        end
        checks++;
        if (mac_payload !== 8'h00 || mac_dest !== 48'h0 || ethertype !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: payload %h dest %h type %h expected 0", mac_payload, mac_dest, ethertype);
        end
        req0 = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_tie();
        sn_rand = 1'b1;
        fork
            begin
                drive_frame(0, 48'h0A0000000001, 16'h0800, 3, 8'h10, -1);
                drive_frame(0, 48'h0A0000000002, 16'h0800, 3, 8'h30, -1);
            end
            drive_frame(1, 48'h0B0000000001, 16'h86DD, 3, 8'h20, -1);
`ifdef TX_ARB_FIXED_PRIO_EN
            watch_grants(3, 0, 0, 1, 1);
`else
            watch_grants(3, 0, 1, 0, 1);
`endif
        join
    endtask

    task automatic test_frame();
        sn_rand = 1'b0;
        drive_frame(0, 48'hFFFFFFFFFFFF, 16'h0806, 3, 8'h01, -1);
    endtask

    task automatic test_one_byte();
        sn_rand = 1'b0;
        drive_frame(0, 48'h020000000001, 16'h0800, 1, 8'hAA, -1);
    endtask

    task automatic test_drop();
        sn_rand = 1'b1;
        drive_frame(1, 48'h0C0000000003, 16'h88B5, 4, 8'h40, 1);
    endtask

    task automatic test_reset_mid();
        int to = 0;
        sn_rand = 1'b0;
        set_in(0, 1'b1, 48'h0D0000000004, 16'h0800, 8'h55, 1'b0);
        @(negedge clk);
        while (!ready0) begin
            to++;
            if (to > 500) begin
                errors++;
                $display("FAIL rst_mid_timeout: ready0 0 expected 1");
                break;
            end
            @(negedge clk);
        end
        if (ready0) sb.push_back(8'h55);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (en !== 1'b0 || grant0 !== 1'b0 || grant1 !== 1'b0 || mac_payload !== 8'h00 ||
            mac_dest !== 48'h0 || ethertype !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid: en %b grant %b%b payload %h dest %h type %h expected all 0",
                     en, grant1, grant0, mac_payload, mac_dest, ethertype);
        end
        set_in(0, 1'b0, 48'h0, 16'h0, 8'h00, 1'b0);
        rst = 1'b0;
        fork
            drive_frame(0, 48'h0E0000000005, 16'h0800, 1, 8'h61, -1);
            drive_frame(1, 48'h0E0000000006, 16'h0800, 1, 8'h71, -1);
            watch_grants(2, 0, 1, 0, 1);
        join
    endtask

    initial begin
        test_reset();
        test_tie();
        test_frame();
        test_one_byte();
        test_drop();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
